load_store_unit: RTL and testbench

- Initiator side of the data-memory interface for the RV32E core.
- Accepts load/store requests from EX and computes the effective byte address.
- Drives the byte-addressed, misalignment-capable data memory group (fixed read latency).
- Tracks in-flight loads through that latency, then sign/zero-extends read data and returns it with its destination register to WB; range and encoding faults are flagged.

---
 rtl/load_store_unit.sv | 160 ++++++++++++++++
 tb/tb_load_store_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit for the RV32E core: initiator side of the data-memory group.
// Computes the effective address, drives the memory group, tracks in-flight
// loads through the fixed read latency, and extends the returned read data.
module load_store_unit #(
  parameter int DATA_DEPTH  = 4096,
  parameter int MEM_LATENCY = 3,
  parameter int ADDR_WIDTH  = 2 + $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_base,
  input  logic [31:0]           req_offset,
  input  logic [31:0]           req_store_data,
  input  logic [3:0]            req_rd,
  input  logic                  flush,
  output logic                  mem_we,
  output logic [1:0]            mem_data_width,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data,
  output logic                  load_valid,
  output logic [3:0]            load_rd,
  output logic [31:0]           load_data,
  output logic                  fault_valid,
  output logic [31:0]           fault_addr,
  output logic                  fault_is_store
);

  // Memory-group width codes; funct3[1:0] maps onto them directly.
  localparam logic [1:0] WIDTH_BYTE  = 2'b00;
  localparam logic [1:0] WIDTH_SHORT = 2'b01;
  localparam logic [1:0] WIDTH_WORD  = 2'b10;

  // First byte address past the end of the memory group (33 bits so that
  // an access ending just below 2^32 cannot wrap back into range).
  localparam logic [32:0] ADDR_LIMIT = 33'(4 * DATA_DEPTH);

  // One entry of the load-tracking shift register.
  typedef struct packed {
    logic       valid;
    logic [3:0] rd;
    logic [1:0] width;
    logic       unsgn;
  } slot_t;

  slot_t       r_slot [MEM_LATENCY];
  logic        r_store_last;
  logic        r_fault_valid;
  logic [31:0] r_fault_addr;
  logic        r_fault_is_store;

  logic [31:0] w_ea;
  logic [32:0] w_size;
  logic [32:0] w_end;
  logic        w_illegal;
  logic        w_range;
  logic        w_fault;
  logic        w_accept;
  logic        w_load_ok;
  slot_t       w_new_slot;
  slot_t       w_last_slot;

  assign w_ea = req_base + req_offset;

  // Access size in bytes for the range check.
  always_comb begin
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    w_size = 33'd4;
    case (req_funct3[1:0])
      WIDTH_BYTE:  w_size = 33'd1;
      WIDTH_SHORT: w_size = 33'd2;
      default:     w_size = 33'd4;
    endcase
  end

  assign w_end     = {1'b0, w_ea} + w_size - 33'd1;
  assign w_range   = (w_end >= ADDR_LIMIT) || ({1'b0, w_ea} >= ADDR_LIMIT);
  assign w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                     (req_we && req_funct3[2]);
  assign w_fault   = w_illegal || w_range;

  // Loads stall for one cycle behind a store whose write lands a cycle late;
  // nothing is accepted while the pipeline is being redirected.
  assign req_ready = !flush && !(r_store_last && !req_we);
  assign w_accept  = req_valid && req_ready;
  assign w_load_ok = w_accept && !req_we && !w_fault;

  assign mem_we         = w_accept && req_we && !w_fault;
  assign mem_addr       = w_ea[ADDR_WIDTH-1:0];
  assign mem_data_width = req_funct3[1:0];
  assign mem_write_data = req_store_data;

  assign w_new_slot = '{valid: w_load_ok, rd: req_rd,
                        width: req_funct3[1:0], unsgn: req_funct3[2]};

  // Remember an accepted store for the load-after-store stall.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) r_store_last <= 1'b0;
    else     r_store_last <= mem_we;
  end

  // Register the fault report one cycle after the faulting request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fault_valid    <= 1'b0;
      r_fault_addr     <= 32'd0;
      r_fault_is_store <= 1'b0;
    end else begin
      r_fault_valid <= w_accept && w_fault;
      if (w_accept && w_fault) begin
        r_fault_addr     <= w_ea;
        r_fault_is_store <= req_we;
      end
    end
  end

  // Advance the load-tracking shift register every clock; flush kills all.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits need a reset; rd/width/unsigned are don't
      // care while invalid, so they stay plain storage without reset logic.
      for (int i = 0; i < MEM_LATENCY; i++) r_slot[i].valid <= 1'b0;
    end else begin
      r_slot[0] <= w_new_slot;
      for (int i = 1; i < MEM_LATENCY; i++) r_slot[i] <= r_slot[i-1];
      if (flush) begin
        for (int i = 0; i < MEM_LATENCY; i++) r_slot[i].valid <= 1'b0;
      end
    end
  end

  assign w_last_slot = r_slot[MEM_LATENCY-1];
  assign load_valid  = w_last_slot.valid;
  assign load_rd     = w_last_slot.rd;

  // Extend the returned read word according to the tracked width/signedness.
  always_comb begin
    load_data = mem_read_data;
    case (w_last_slot.width)
      WIDTH_BYTE:  load_data = {{24{!w_last_slot.unsgn && mem_read_data[7]}},
                                mem_read_data[7:0]};
      WIDTH_SHORT: load_data = {{16{!w_last_slot.unsgn && mem_read_data[15]}},
                                mem_read_data[15:0]};
      WIDTH_WORD:  load_data = mem_read_data;
      default:     load_data = mem_read_data;
    endcase
  end

  assign fault_valid    = r_fault_valid;
  assign fault_addr     = r_fault_addr;
  assign fault_is_store = r_fault_is_store;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a behavioural memory group
// (write lands one cycle late, read data valid MEM_LATENCY cycles later).
module tb_load_store_unit;

  localparam int DATA_DEPTH  = 4096;
  localparam int MEM_LATENCY = 3;
  localparam int ADDR_WIDTH  = 14;
  localparam int MEM_BYTES   = 4 * DATA_DEPTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [31:0]           req_base;
  logic [31:0]           req_offset;
  logic [31:0]           req_store_data;
  logic [3:0]            req_rd;
  logic                  flush;
  logic                  mem_we;
  logic [1:0]            mem_data_width;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_write_data;
  logic [31:0]           mem_read_data;
  logic                  load_valid;
  logic [3:0]            load_rd;
  logic [31:0]           load_data;
  logic                  fault_valid;
  logic [31:0]           fault_addr;
  logic                  fault_is_store;

  load_store_unit #(
    .DATA_DEPTH (DATA_DEPTH),
    .MEM_LATENCY(MEM_LATENCY)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_base      (req_base),
    .req_offset    (req_offset),
    .req_store_data(req_store_data),
    .req_rd        (req_rd),
    .flush         (flush),
    .mem_we        (mem_we),
    .mem_data_width(mem_data_width),
    .mem_addr      (mem_addr),
    .mem_write_data(mem_write_data),
    .mem_read_data (mem_read_data),
    .load_valid    (load_valid),
    .load_rd       (load_rd),
    .load_data     (load_data),
    .fault_valid   (fault_valid),
    .fault_addr    (fault_addr),
    .fault_is_store(fault_is_store)
  );

  always #5 clk = ~clk;

  // Behavioural memory group.
  logic [7:0]            mem [0:MEM_BYTES-1] = '{default: 8'h00};
  logic                  p_we = 1'b0;
  logic [ADDR_WIDTH-1:0] p_addr = '0;
  logic [31:0]           p_data = '0;
  logic [1:0]            p_width = '0;
  logic [ADDR_WIDTH-1:0] a0 = '0, a1 = '0, a2 = '0;

  always @(posedge clk) begin
    if (p_we) begin
      for (int k = 0; k < 4; k++) begin
        if (k == 0 || (k == 1 && p_width != 2'b00) || p_width == 2'b10)
          mem[ADDR_WIDTH'(p_addr + ADDR_WIDTH'(k))] <= p_data[8*k +: 8];
      end
    end
    p_we    <= mem_we;
    p_addr  <= mem_addr;
    p_data  <= mem_write_data;
    p_width <= mem_data_width;
    a0 <= mem_addr;
    a1 <= a0;
    a2 <= a1;
  end

  always_comb begin
    mem_read_data = {mem[ADDR_WIDTH'(a2 + 3)], mem[ADDR_WIDTH'(a2 + 2)],
                     mem[ADDR_WIDTH'(a2 + 1)], mem[a2]};
  end

  // Cycle counter and load-return / write-pulse monitor.
  int          cyc = 0;
  logic [3:0]  ev_rd [$];
  logic [31:0] ev_data [$];
  int          ev_cyc [$];
  int          we_pulses = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_valid === 1'b1) begin
      ev_rd.push_back(load_rd);
      ev_data.push_back(load_data);
      ev_cyc.push_back(cyc);
    end
    if (mem_we === 1'b1) we_pulses++;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic chk_ev(input string tag, input int idx, input logic [3:0] rd,
                        input logic [31:0] data, input int at_cyc);
    if (idx < ev_rd.size()) begin
      check({tag, "_rd"}, 32'(ev_rd[idx]), 32'(rd));
      check({tag, "_data"}, ev_data[idx], data);
      check({tag, "_cyc"}, 32'(ev_cyc[idx]), 32'(at_cyc));
    end else begin
      check({tag, "_present"}, 32'(ev_rd.size()), 32'(idx + 1));
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid      = 1'b0;
    req_we         = 1'b0;
    req_funct3     = 3'b000;
    req_base       = 32'd0;
    req_offset     = 32'd0;
    req_store_data = 32'd0;
    req_rd         = 4'd0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3,
                       input logic [31:0] base, input logic [31:0] off,
                       input logic [31:0] data, input logic [3:0] rd);
    req_valid      = 1'b1;
    req_we         = we;
    req_funct3     = f3;
    req_base       = base;
    req_offset     = off;
    req_store_data = data;
    req_rd         = rd;
  endtask

  // Back-to-back load table: LB, LBU, LH, LHU over the word DEADBEEF @0x10.
  logic [2:0]  bb_f3   [4] = '{3'b000, 3'b100, 3'b001, 3'b101};
  logic [31:0] bb_addr [4] = '{32'h13, 32'h13, 32'h11, 32'h11};
  logic [31:0] bb_exp  [4] = '{32'hFFFF_FFDE, 32'h0000_00DE,
                               32'hFFFF_ADBE, 32'h0000_ADBE};

  initial begin
    int t0;
    int base_ev;
    int we0;

    idle();
    flush = 1'b0;
    rst   = 1'b1;
    next();
    next();
    rst = 1'b0;
    #1;
    check("rst_load_valid", 32'(load_valid), 32'd0);
    check("rst_fault_valid", 32'(fault_valid), 32'd0);
    check("rst_fault_addr", fault_addr, 32'd0);
    check("rst_fault_is_store", 32'(fault_is_store), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    next();

    // Store then load with the one-cycle stall.
    drive(1'b1, 3'b010, 32'h8, 32'h8, 32'hDEAD_BEEF, 4'd0);
    #1;
    check("sw_mem_we", 32'(mem_we), 32'd1);
    check("sw_mem_addr", 32'(mem_addr), 32'h10);
    check("sw_width", 32'(mem_data_width), 32'd2);
    check("sw_ready", 32'(req_ready), 32'd1);
    next();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd5);
    #1;
    check("stall_ready", 32'(req_ready), 32'd0);
    check("stall_mem_we", 32'(mem_we), 32'd0);
    next();
    #1;
    check("lw_ready", 32'(req_ready), 32'd1);
    t0      = cyc;
    base_ev = ev_rd.size();
    next();
    idle();
    repeat (4) next();
    check("lw_count", 32'(ev_rd.size()), 32'(base_ev + 1));
    chk_ev("lw", base_ev, 4'd5, 32'hDEAD_BEEF, t0 + MEM_LATENCY);

    // Four back-to-back loads exercising extension.
    base_ev = ev_rd.size();
    t0      = cyc;
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, bb_f3[j], bb_addr[j], 32'h0, 32'h0, 4'(j + 1));
      #1;
      check("bb_ready", 32'(req_ready), 32'd1);
      next();
    end
    idle();
    repeat (6) next();
    check("bb_count", 32'(ev_rd.size()), 32'(base_ev + 4));
    for (int j = 0; j < 4; j++)
      chk_ev("bb", base_ev + j, 4'(j + 1), bb_exp[j], t0 + j + MEM_LATENCY);

    // Range and encoding faults.
    base_ev = ev_rd.size();
    we0     = we_pulses;
    drive(1'b0, 3'b010, 32'h3FFE, 32'h0, 32'h0, 4'd6);
    #1;
    check("flt_lw_we", 32'(mem_we), 32'd0);
    next();
    idle();
    #1;
    check("flt_lw_valid", 32'(fault_valid), 32'd1);
    check("flt_lw_addr", fault_addr, 32'h3FFE);
    check("flt_lw_store", 32'(fault_is_store), 32'd0);
    next();
    #1;
    check("flt_pulse", 32'(fault_valid), 32'd0);
    drive(1'b1, 3'b010, 32'h4000, 32'h0, 32'h1234_5678, 4'd0);
    next();
    idle();
    #1;
    check("flt_sw_valid", 32'(fault_valid), 32'd1);
    check("flt_sw_addr", fault_addr, 32'h4000);
    check("flt_sw_store", 32'(fault_is_store), 32'd1);
    next();
    drive(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 4'd6);
    next();
    idle();
    #1;
    check("flt_f3_valid", 32'(fault_valid), 32'd1);
    check("flt_f3_addr", fault_addr, 32'h20);
    check("flt_f3_store", 32'(fault_is_store), 32'd0);
    next();
    drive(1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 4'd0);
    next();
    idle();
    #1;
    check("flt_su_valid", 32'(fault_valid), 32'd1);
    check("flt_su_store", 32'(fault_is_store), 32'd1);
    next();
    drive(1'b0, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0, 4'd6);
    next();
    idle();
    #1;
    check("flt_hi_valid", 32'(fault_valid), 32'd1);
    check("flt_hi_addr", fault_addr, 32'hFFFF_FFFF);
    repeat (5) next();
    check("flt_no_we", 32'(we_pulses - we0), 32'd0);
    check("flt_no_load", 32'(ev_rd.size()), 32'(base_ev));

    // Legal edge cases: last byte, and a wrapping effective address.
    base_ev = ev_rd.size();
    t0      = cyc;
    drive(1'b0, 3'b100, 32'h3FFF, 32'h0, 32'h0, 4'd6);
    next();
    drive(1'b0, 3'b010, 32'hFFFF_FFFF, 32'h11, 32'h0, 4'd7);
    #1;
    check("edge_lbu_nofault", 32'(fault_valid), 32'd0);
    check("wrap_addr", 32'(mem_addr), 32'h10);
    next();
    idle();
    #1;
    check("wrap_nofault", 32'(fault_valid), 32'd0);
    repeat (5) next();
    chk_ev("edge", base_ev, 4'd6, 32'h0, t0 + MEM_LATENCY);
    chk_ev("wrap", base_ev + 1, 4'd7, 32'hDEAD_BEEF, t0 + 1 + MEM_LATENCY);

    // Flush kills both in-flight loads and blocks the request beside it.
    base_ev = ev_rd.size();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd8);
    next();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd9);
    next();
    drive(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 4'd9);
    flush = 1'b1;
    #1;
    check("flush_ready", 32'(req_ready), 32'd0);
    next();
    idle();
    flush = 1'b0;
    #1;
    check("flush_nofault", 32'(fault_valid), 32'd0);
    repeat (5) next();
    check("flush_no_load", 32'(ev_rd.size()), 32'(base_ev));
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd10);
    t0 = cyc;
    next();
    idle();
    repeat (4) next();
    chk_ev("post_flush", base_ev, 4'd10, 32'hDEAD_BEEF, t0 + MEM_LATENCY);

    // Reset with two loads in flight.
    base_ev = ev_rd.size();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd11);
    next();
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd12);
    next();
    idle();
    rst = 1'b1;
    next();
    rst = 1'b0;
    #1;
    check("mid_rst_load_valid", 32'(load_valid), 32'd0);
    check("mid_rst_fault_valid", 32'(fault_valid), 32'd0);
    check("mid_rst_fault_addr", fault_addr, 32'd0);
    check("mid_rst_fault_store", 32'(fault_is_store), 32'd0);
    repeat (6) next();
    check("mid_rst_no_load", 32'(ev_rd.size()), 32'(base_ev));

    // Reset also clears the pending load-after-store stall.
    drive(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 4'd0);
    next();
    idle();
    rst = 1'b1;
    next();
    rst = 1'b0;
    drive(1'b0, 3'b010, 32'h10, 32'h0, 32'h0, 4'd13);
    #1;
    check("rst_stall_clear", 32'(req_ready), 32'd1);
    t0 = cyc;
    next();
    idle();
    repeat (4) next();
    check("post_rst_count", 32'(ev_rd.size()), 32'(base_ev + 1));
    chk_ev("post_rst", base_ev, 4'd13, 32'hDEAD_BEEF, t0 + MEM_LATENCY);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
